// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } arb_owner_t;

    localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Saturating event counter with enable; holds at all-ones instead of wrapping.
module mem_arb_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (en && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// Define MEM_ARB_PERF_EN to build the contention counter on perf_wait_cnt.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [2:0]        ls_funct3,
    output logic              ls_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       perf_wait_cnt
);

    arb_state_t        state_reg;
    arb_owner_t        owner_reg;
    arb_owner_t        last_grant_reg;
    logic              mem_req_reg;
    logic              wen_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [2:0]        funct3_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              if_done_reg;
    logic              ls_done_reg;
    logic              grant_ls;

    // LS wins when alone, or on a tie when IF was served last.
    assign grant_ls = ls_req & (~if_req | (last_grant_reg == OWN_IF));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= OWN_IF;
            last_grant_reg <= OWN_IF;
            mem_req_reg    <= 1'b0;
            wen_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            funct3_reg     <= '0;
            rdata_reg      <= '0;
            if_done_reg    <= 1'b0;
            ls_done_reg    <= 1'b0;
        end else begin
            if_done_reg <= 1'b0;
            ls_done_reg <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (if_req || ls_req) begin
                        state_reg   <= ARB_BUSY;
                        mem_req_reg <= 1'b1;
                        if (grant_ls) begin
                            owner_reg      <= OWN_LS;
                            last_grant_reg <= OWN_LS;
                            addr_reg       <= ls_addr;
                            wen_reg        <= ls_wen;
                            wdata_reg      <= ls_wdata;
                            funct3_reg     <= ls_funct3;
                        end else begin
                            owner_reg      <= OWN_IF;
                            last_grant_reg <= OWN_IF;
                            addr_reg       <= if_addr;
                            wen_reg        <= 1'b0;
                            wdata_reg      <= '0;
                            funct3_reg     <= FETCH_FUNCT3;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (mem_ready) begin
                        state_reg   <= ARB_RESP;
                        mem_req_reg <= 1'b0;
                        // A store returns no data, so the response word is zero.
                        rdata_reg   <= wen_reg ? '0 : mem_rdata;
                        if (owner_reg == OWN_LS) begin
                            ls_done_reg <= 1'b1;
                        end else begin
                            if_done_reg <= 1'b1;
                        end
                    end
                end
                ARB_RESP: begin
                    state_reg <= ARB_IDLE;
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_reg;
    assign mem_addr   = addr_reg;
    assign mem_wen    = wen_reg & mem_req_reg;
    assign mem_wdata  = wdata_reg;
    assign mem_funct3 = funct3_reg;
    assign rdata      = rdata_reg;
    assign if_done    = if_done_reg;
    assign ls_done    = ls_done_reg;

`ifdef MEM_ARB_PERF_EN
    logic access_active;
    logic wait_en;

    // A requester waits whenever it asks but does not own the access in flight.
    assign access_active = (state_reg != ARB_IDLE);
    assign wait_en = (if_req & ~(access_active & (owner_reg == OWN_IF))) |
                     (ls_req & ~(access_active & (owner_reg == OWN_LS)));

    mem_arb_perf_cnt #(
        .WIDTH(32)
    ) u_perf_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (wait_en),
        .count (perf_wait_cnt)
    );
`else
    assign perf_wait_cnt = '0;
`endif

endmodule
